fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch queue between the PC register and the ID stage. Tags each
//  synchronous instruction-memory read with its PC and buffers {pc, instr} pairs
//  in a DEPTH-entry FIFO. Presents them to ID with a valid/ready handshake.
//  Drives the PC stall (stop_o) for backpressure and drops wrong-path work on a branch.
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >= 2
//  XLEN   32  PC / instruction width
// PORTS
//  clk         in   1     clock
//  rst         in   1     reset, synchronous, active-high
//  pc_i        in   XLEN  current PC; this cycle's imem address
//  imem_rdata  in   XLEN  imem read data; 1 cycle after address
//  flush_i     in   1     branch taken (same signal as PC branch_flag)
//  stop_o      out  1     hold PC (to PC stop input)
//  id_ready_i  in   1     ID stage accepts the head entry
//  id_valid_o  out  1     head entry valid
//  id_pc_o     out  XLEN  PC of head entry
//  id_npc_o    out  XLEN  id_pc_o + 4, modulo 2^XLEN
//  id_instr_o  out  XLEN  instruction of head entry
//  count_o     out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - State: storage[DEPTH] of {pc, instr}; wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits,
//    wrap with an extra MSB; count = wr_ptr - rd_ptr; req_q (fetch in flight); pc_q.
//  - Issue: each cycle, pc_q <= pc_i; req_q <= !rst && !stop_o && !flush_i.
//  - Enqueue: enq = req_q. Writes {pc_q, imem_rdata} at wr_ptr.
//  - Backpressure: stop_o = (count + req_q >= DEPTH), combinational.
//    An enqueue therefore never meets a full queue.
//  - Dequeue: deq = id_valid_o && id_ready_i; id_valid_o = (count != 0).
//    The id_* outputs read storage[rd_ptr] combinationally.
//  - Enqueue and dequeue in the same cycle: both take effect; count unchanged.
//  - flush_i (priority over all): wr_ptr = rd_ptr = 0 and req_q = 0 next cycle.
//    Enqueue and dequeue that cycle are discarded. First target instruction is
//    enqueued 2 cycles after flush_i (PC loads the target, then imem read).
//  - Latency: PC issue -> enqueue +1 cycle -> id_valid_o +2 cycles (no bypass).
//  - Reset: pointers 0, req_q 0, pc_q 0. Outputs then: id_valid_o=0, stop_o=0,
//    count_o=0. id_pc_o/id_instr_o are don't-care while id_valid_o=0.
//  - Reset mid-operation: all queued and in-flight fetches are dropped.
//  - id_ready_i is ignored while id_valid_o=0. id_valid_o never drops without
//    deq or flush_i. The head entry stays stable while stalled.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined: when count==0 && req_q && !flush_i,
//    id_valid_o=1 and id_* = {pc_q, imem_rdata} in the same cycle (1 cycle
//    issue->ID). If id_ready_i is also set, the entry is consumed and not written.
//    Otherwise it is written normally.
//  Undefined: no bypass; an entry is visible only the cycle after enqueue.
// TESTING
//  1 rst 3 cycles; pc_i=0x0,4,8.., imem=0x13+pc, ready=1 -> id_pc 0x0,0x4,0x8
//    on consecutive cycles; first valid 2 cycles after rst low (1 with BYPASS).
//  2 id_ready_i=0 for 10 cycles, DEPTH=4 -> count_o reaches 4, stop_o=1. Queue
//    holds 0x0..0xC; no duplicates or drops after ready returns.
//  3 flush_i with pc_i=0x8, target 0x40 next cycle -> count_o=0, and 0x8/0xC
//    never reach ID; next id_pc_o=0x40.
//  4 flush_i while full and ready=0 -> next cycle id_valid_o=0, stop_o=0.
//  5 rst asserted while count=3, req_q=1 -> next cycle count_o=0, id_valid_o=0.
//  6 pc_i=0xFFFF_FFFC enqueued -> id_npc_o=0x0000_0000; random ready toggling
//    vs. a scoreboard shows in-order, lossless, duplicate-free delivery.

Source files
------------

// File: rtl/fetch_queue_if.sv
// ID-side handshake bundle of the fetch queue.
//   master : fetch queue (drives valid and the head entry, samples ready)
//   slave  : ID stage   (samples valid and the head entry, drives ready)
// Signals:
//   id_valid_o  head entry valid
//   id_ready_i  ID stage accepts the head entry
//   id_pc_o     PC of head entry
//   id_npc_o    id_pc_o + 4, modulo 2^XLEN
//   id_instr_o  instruction of head entry
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            id_valid_o;
  logic            id_ready_i;
  logic [XLEN-1:0] id_pc_o;
  logic [XLEN-1:0] id_npc_o;
  logic [XLEN-1:0] id_instr_o;

  modport master (
    output id_valid_o, id_pc_o, id_npc_o, id_instr_o,
    input  id_ready_i
  );

  modport slave (
    input  id_valid_o, id_pc_o, id_npc_o, id_instr_o,
    output id_ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC register and the ID stage.
// Tags every synchronous imem read with its PC and buffers {pc, instr} pairs
// in a DEPTH-entry FIFO, handed to ID over a valid/ready handshake. Stalls the
// PC (stop_o) before the queue can overflow and drops wrong-path work on a
// taken branch (flush_i).
// Parameters: DEPTH (entries, power of two, >= 2), XLEN (PC/instr width).
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   pc_i        current PC, this cycle's imem address
//   imem_rdata  imem read data, one cycle after the address
//   flush_i     branch taken; clears queue and in-flight fetch
//   stop_o      hold PC
//   id          ID handshake (fetch_queue_if.master)
//   count_o     occupancy
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward the in-flight
// fetch straight to ID when the queue is empty (1-cycle issue->ID).
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   flush_i,
  output logic                   stop_o,
  fetch_queue_if.master          id,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          storage [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     count;
  logic [AW+1:0]   occ;
  logic            req_q;
  logic [XLEN-1:0] pc_q;
  logic            bypass_take;
  logic            wr_en;
  logic            rd_en;
  entry_t          head;

  always_comb begin
    count       = wr_ptr - rd_ptr;
    // Counting the in-flight fetch guarantees its enqueue never meets a full queue.
    occ         = {1'b0, count} + (AW+2)'(req_q);
    stop_o      = (occ >= (AW+2)'(DEPTH));
    bypass_take = 1'b0;
    head        = storage[rd_ptr[AW-1:0]];
    id.id_valid_o = (count != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    if ((count == '0) && req_q && !flush_i) begin
      id.id_valid_o = 1'b1;
      head.pc       = pc_q;
      head.instr    = imem_rdata;
      bypass_take   = id.id_ready_i;
    end
`endif
    // Storage is only popped when it holds something; a bypassed entry is
    // consumed without ever being written.
    rd_en         = (count != '0) && id.id_ready_i;
    wr_en         = req_q && !bypass_take;
    id.id_pc_o    = head.pc;
    id.id_npc_o   = head.pc + XLEN'(4);
    id.id_instr_o = head.instr;
    count_o       = count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_q  <= 1'b0;
      pc_q   <= '0;
    end else begin
      pc_q  <= pc_i;
      req_q <= !stop_o && !flush_i;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && wr_en)
      storage[wr_ptr[AW-1:0]] <= {pc_q, imem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + randomised bench for fetch_queue. A PC register and a
// synchronous imem (data = address + 0x13) surround the DUT; every issued PC
// is pushed to a scoreboard and popped when ID accepts an entry.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  imem_rdata;
  logic             flush_i;
  logic             stop_o;
  logic [$clog2(DEPTH):0] count_o;

  fetch_queue_if #(.XLEN(XLEN)) id_bus ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .imem_rdata (imem_rdata),
    .flush_i    (flush_i),
    .stop_o     (stop_o),
    .id         (id_bus.master),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb [$];
  logic [31:0] pc_reg;
  logic [31:0] target;
  logic        last_issue;
  logic        held_valid;
  logic [31:0] held_pc;
  logic [31:0] held_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called just after a negedge with inputs already set.
  task automatic cycle();
    logic [31:0] exp_pc;
    int          exp_count;
    logic        exp_valid;
    logic        c_rst, c_flush, c_stop, issue;
    logic [31:0] c_pc;
    #2;
    if (!rst) begin
      exp_count = sb.size() - int'(last_issue);
      check("count", 32'(count_o), 32'(exp_count));
      check("stop", 32'(stop_o), 32'(sb.size() >= DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
      exp_valid = (exp_count != 0) || (last_issue && !flush_i);
`else
      exp_valid = (exp_count != 0);
`endif
      check("valid", 32'(id_bus.id_valid_o), 32'(exp_valid));
      if (held_valid) begin
        check("stall_pc", id_bus.id_pc_o, held_pc);
        check("stall_instr", id_bus.id_instr_o, held_instr);
      end
      if (!flush_i && id_bus.id_valid_o && id_bus.id_ready_i) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_pc = sb.pop_front();
          check("deq_pc", id_bus.id_pc_o, exp_pc);
          check("deq_instr", id_bus.id_instr_o, exp_pc + 32'h13);
          check("deq_npc", id_bus.id_npc_o, exp_pc + 32'd4);
        end
      end
    end
    c_rst   = rst;
    c_flush = flush_i;
    c_stop  = stop_o;
    c_pc    = pc_i;
    issue   = !c_rst && !c_stop && !c_flush;
    held_valid = !c_rst && !c_flush && id_bus.id_valid_o && !id_bus.id_ready_i;
    held_pc    = id_bus.id_pc_o;
    held_instr = id_bus.id_instr_o;
    @(posedge clk);
    #1;
    if (c_rst || c_flush) sb.delete();
    if (issue) sb.push_back(c_pc);
    last_issue = issue;
    imem_rdata = c_pc + 32'h13;
    if (c_rst)        pc_reg = 32'h0;
    else if (c_flush) pc_reg = target;
    else if (!c_stop) pc_reg = pc_reg + 32'd4;
    pc_i = pc_reg;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    flush_i    = 1'b0;
    target     = 32'h0;
    pc_reg     = 32'h0;
    pc_i       = 32'h0;
    imem_rdata = 32'h0;
    last_issue = 1'b0;
    held_valid = 1'b0;
    id_bus.id_ready_i = 1'b1;
    @(negedge clk);

    // 1: reset state, first-valid latency, consecutive delivery
    do_reset();
    #1;
    check("rst_valid", 32'(id_bus.id_valid_o), 32'd0);
    check("rst_stop", 32'(stop_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    cycle();
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("first_valid_lat", 32'(id_bus.id_valid_o), 32'd1);
    check("first_pc", id_bus.id_pc_o, 32'h0);
    cycle();
`else
    check("first_valid_early", 32'(id_bus.id_valid_o), 32'd0);
    cycle();
    #1;
    check("first_valid_lat", 32'(id_bus.id_valid_o), 32'd1);
    check("first_pc", id_bus.id_pc_o, 32'h0);
`endif
    for (int i = 0; i < 6; i++) cycle();

    // 2: backpressure fills the queue, then drains losslessly
    id_bus.id_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    #1;
    check("full_count", 32'(count_o), 32'd4);
    check("full_stop", 32'(stop_o), 32'd1);
    id_bus.id_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // 3: flush with pc_i=0x8, target 0x40
    do_reset();
    for (int i = 0; i < 5 && pc_i != 32'h8; i++) cycle();
    check("t3_pc8", pc_i, 32'h8);
    flush_i = 1'b1;
    target  = 32'h40;
    cycle();
    flush_i = 1'b0;
    #1;
    check("t3_count", 32'(count_o), 32'd0);
    for (int i = 0; i < 5 && !id_bus.id_valid_o; i++) cycle();
    #1;
    check("t3_target_pc", id_bus.id_pc_o, 32'h40);
    for (int i = 0; i < 4; i++) cycle();

    // 4: flush while full and stalled
    id_bus.id_ready_i = 1'b0;
    for (int i = 0; i < 12 && !stop_o; i++) cycle();
    for (int i = 0; i < 2; i++) cycle();
    #1;
    check("t4_full", 32'(count_o), 32'd4);
    flush_i = 1'b1;
    target  = 32'h100;
    cycle();
    flush_i = 1'b0;
    #1;
    check("t4_valid", 32'(id_bus.id_valid_o), 32'd0);
    check("t4_stop", 32'(stop_o), 32'd0);

    // 5: reset mid-operation with count=3 and a fetch in flight
    for (int i = 0; i < 8 && count_o != 3; i++) cycle();
    #1;
    check("t5_count3", 32'(count_o), 32'd3);
    check("t5_inflight", 32'(last_issue), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("t5_count", 32'(count_o), 32'd0);
    check("t5_valid", 32'(id_bus.id_valid_o), 32'd0);

    // 6: PC wrap boundary, then random ready toggling
    flush_i = 1'b1;
    target  = 32'hFFFF_FFFC;
    cycle();
    flush_i = 1'b0;
    for (int i = 0; i < 6 && !id_bus.id_valid_o; i++) cycle();
    #1;
    check("t6_pc", id_bus.id_pc_o, 32'hFFFF_FFFC);
    check("t6_npc", id_bus.id_npc_o, 32'h0000_0000);
    for (int i = 0; i < 300; i++) begin
      id_bus.id_ready_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        flush_i = 1'b1;
        target  = 32'($urandom_range(0, 255)) << 2;
      end
      cycle();
      flush_i = 1'b0;
    end
    id_bus.id_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
